// File: rtl/add_seq_ctrl_if.sv
// Request/result bundle for the shared serial adder: two operand producers and one result consumer.
interface add_seq_ctrl_if #(parameter int WORDS = 4);
  localparam int W = 4 * WORDS;

  logic         req0_valid, req0_ready, req0_ci;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_ci;
  logic [W-1:0] req1_a, req1_b;
  logic         res_valid, res_ready, res_co, res_id, busy;
  logic [W-1:0] res_sum;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ci,
    input  req1_valid, req1_a, req1_b, req1_ci,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_co, res_id, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ci,
    output req1_valid, req1_a, req1_b, req1_ci,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_co, res_id, busy
  );
endinterface

// File: rtl/add_seq_ctrl.sv
// Round-robin scheduler sharing one 4-bit adder slice between two requesters;
// operands are added one nibble per cycle, LSB first, carry chained through a register.
module add_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'd0, ci};
endmodule

module add_seq_ctrl #(parameter int WORDS = 4) (
  input  logic          clk,
  input  logic          rst_n,
  add_seq_ctrl_if.slave bus
);
  localparam int W  = 4 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_r, b_r, sum_r;
  logic [IW-1:0] idx;
  logic          carry, co_r, id_r, vld_r, busy_r, last_grant;
  logic          grant0, grant1;
  logic [3:0]    nib_s;
  logic          nib_co;

  // Tie goes to whoever did not win last; a lone requester always wins.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);

  assign bus.req0_ready = (state == IDLE) & grant0;
  assign bus.req1_ready = (state == IDLE) & grant1;

  add_4 u_add (
    .a  (a_r[4*idx +: 4]),
    .b  (b_r[4*idx +: 4]),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      sum_r      <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      co_r       <= 1'b0;
      id_r       <= 1'b0;
      vld_r      <= 1'b0;
      busy_r     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0_ready | bus.req1_ready) begin
            a_r        <= bus.req1_ready ? bus.req1_a  : bus.req0_a;
            b_r        <= bus.req1_ready ? bus.req1_b  : bus.req0_b;
            carry      <= bus.req1_ready ? bus.req1_ci : bus.req0_ci;
            id_r       <= bus.req1_ready;
            last_grant <= bus.req1_ready;
            idx        <= '0;
            busy_r     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_r[4*idx +: 4] <= nib_s;
          carry             <= nib_co;
          if (idx == IW'(WORDS - 1)) begin
            co_r  <= nib_co;
            vld_r <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            vld_r  <= 1'b0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.res_valid = vld_r;
  assign bus.res_sum   = sum_r;
  assign bus.res_co    = co_r;
  assign bus.res_id    = id_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl (WORDS=4): single adds, carry cases, round-robin,
// backpressure and reset mid-RUN.
module tb_add_seq_ctrl;
  localparam int WORDS = 4;
  localparam int W     = 4 * WORDS;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  add_seq_ctrl_if #(.WORDS(WORDS)) bus ();
  add_seq_ctrl #(.WORDS(WORDS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.res_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Sole request, result latency counted with the accept edge as edge 1.
  task automatic run_one(input string tag, input logic id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci,
                         input logic [W-1:0] esum, input logic eco);
    int n;
    @(negedge clk);
    if (id) begin bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_ci = ci; end
    else    begin bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_ci = ci; end
    #1;
    chk({tag, "_rdy"}, id ? bus.req1_ready : bus.req0_ready, 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk({tag, "_busy"}, bus.busy, 1);
    wait_valid(n);
    chk({tag, "_lat"}, n, WORDS + 1);
    @(negedge clk);
    chk({tag, "_vld"}, bus.res_valid, 1);
    chk({tag, "_sum"}, bus.res_sum, esum);
    chk({tag, "_co"},  bus.res_co, eco);
    chk({tag, "_id"},  bus.res_id, id);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk({tag, "_clr"}, bus.res_valid, 0);
    chk({tag, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    int n, gap, last_t;
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ci = 0;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ci = 0;
    bus.res_ready  = 0;
    rst_n = 1'b0;

    do_reset();
    @(negedge clk);
    chk("rst_vld",  bus.res_valid, 0);
    chk("rst_sum",  bus.res_sum, 0);
    chk("rst_co",   bus.res_co, 0);
    chk("rst_id",   bus.res_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rdy",  {bus.req1_ready, bus.req0_ready}, 0);

    run_one("single",  1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run_one("ripple",  1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_one("cinonly", 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_one("msb",     1'b1, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);
    run_one("mid",     1'b0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

    // Round-robin with both requesters held valid and res_ready held high.
    do_reset();
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222; bus.req0_ci = 0;
    bus.req1_valid = 1; bus.req1_a = 16'h0F00; bus.req1_b = 16'h0100; bus.req1_ci = 0;
    bus.res_ready  = 1;
    last_t = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      #1;
      while (!(bus.req0_ready | bus.req1_ready) && n < 40) begin
        @(negedge clk); #1; n++;
      end
      chk("rr_rdy0", bus.req0_ready, (i % 2) == 0);
      chk("rr_rdy1", bus.req1_ready, (i % 2) == 1);
      gap = int'($time) - last_t;
      if (i > 0) chk("rr_gap", gap / 10, WORDS + 2);
      last_t = int'($time);
      n = 0;
      @(negedge clk);
      while (!bus.res_valid && n < 40) begin
        @(negedge clk); n++;
      end
      chk("rr_vld", bus.res_valid, 1);
      chk("rr_id",  bus.res_id, i % 2);
      chk("rr_sum", bus.res_sum, (i % 2) ? 16'h1000 : 16'h3333);
      @(negedge clk);
    end
    bus.req0_valid = 0; bus.req1_valid = 0; bus.res_ready = 0;

    // Backpressure: result held for 3 cycles while req1 waits.
    do_reset();
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_a = 16'h0102; bus.req0_b = 16'h0304; bus.req0_ci = 1;
    @(posedge clk); #1;
    bus.req0_valid = 0;
    bus.req1_valid = 1; bus.req1_a = 16'h7000; bus.req1_b = 16'h1000; bus.req1_ci = 0;
    wait_valid(n);
    chk("bp_vld", bus.res_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_vld", bus.res_valid, 1);
      chk("bp_hold_sum", bus.res_sum, 16'h0407);
      chk("bp_hold_id",  bus.res_id, 0);
      chk("bp_no_rdy",   {bus.req1_ready, bus.req0_ready}, 0);
    end
    bus.res_ready = 1;
    @(posedge clk); #1;
    bus.res_ready = 0;
    chk("bp_clr",  bus.res_valid, 0);
    chk("bp_pend", bus.req1_ready, 1);
    @(posedge clk); #1;
    bus.req1_valid = 0;
    wait_valid(n);
    @(negedge clk);
    chk("bp2_vld", bus.res_valid, 1);
    chk("bp2_sum", bus.res_sum, 16'h8000);
    chk("bp2_id",  bus.res_id, 1);
    bus.res_ready = 1;
    @(posedge clk); #1;
    bus.res_ready = 0;

    // Reset while RUN is at nibble index 2.
    @(negedge clk);
    bus.req1_valid = 1; bus.req1_a = 16'hABCD; bus.req1_b = 16'h1111; bus.req1_ci = 1;
    @(posedge clk); #1;
    bus.req1_valid = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    @(posedge clk); #1;
    chk("mr_vld",  bus.res_valid, 0);
    chk("mr_sum",  bus.res_sum, 0);
    chk("mr_co",   bus.res_co, 0);
    chk("mr_id",   bus.res_id, 0);
    chk("mr_busy", bus.busy, 0);
    rst_n = 1;
    run_one("after_rst", 1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
